// File: rtl/tone_burst_gen_pkg.sv
// Shared types and constants for the tone-burst generator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: mode enum, FSM state enum, 12-entry chromatic note table
// (half-period base values for the top octave of the scale mode), and
// small helpers used by the top and the note lookup.
package tone_pkg;

  typedef enum logic [1:0] {
    TONE_FIXED = 2'd0,
    TONE_SWEEP = 2'd1,
    TONE_SCALE = 2'd2,
    TONE_RSVD  = 2'd3
  } tone_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tone_state_e;

  localparam int NOTE_CNT = 12;

  // Base half-period counts for one octave, lowest note first.
  localparam logic [9:0] NOTE_LUT [NOTE_CNT] = '{
    10'd512, 10'd483, 10'd456, 10'd431, 10'd406, 10'd384,
    10'd362, 10'd342, 10'd323, 10'd304, 10'd287, 10'd271
  };

  // Width of an octave index; never zero so a single-octave build still
  // has a legal vector.
  function automatic int oct_width(input int octaves);
    return (octaves > 1) ? $clog2(octaves) : 1;
  endfunction

  // Out-of-range note indices fall back to the first entry.
  function automatic logic [9:0] note_base(input logic [3:0] note);
    return (note < 4'(NOTE_CNT)) ? NOTE_LUT[note] : NOTE_LUT[0];
  endfunction

endpackage

// File: rtl/tone_burst_gen_if.sv
// Request/status bundle between a controller and tone_burst_gen.
// Latency: n/a (wires only).
// Backpressure: none; start is a one-cycle request, busy tells the master when it will be ignored.
//
// Signals: start (1-cycle request), mode (2b), bursts (BURST_W),
//          busy, sound, done (all registered by the slave).
// Modports: master drives the request, slave drives status and sound.
interface tone_burst_gen_if #(
  parameter int BURST_W = 4
);
  logic               start;
  logic [1:0]         mode;
  logic [BURST_W-1:0] bursts;
  logic               busy;
  logic               sound;
  logic               done;

  modport master (
    output start, mode, bursts,
    input  busy, sound, done
  );

  modport slave (
    input  start, mode, bursts,
    output busy, sound, done
  );
endinterface

// File: rtl/tone_burst_gen_note_lut.sv
// Scale-mode divider: maps (note, octave) to the half-period reload value.
// Latency: combinational.
// Backpressure: none.
//
// Ports: i_note (0..11), i_oct (0..OCTAVES-1), o_div (DIV_W reload value).
// Octave 0 is the lowest pitch, so it gets the largest left shift.
module tone_note_lut
  import tone_pkg::*;
#(
  parameter int DIV_W   = 15,
  parameter int OCTAVES = 6,
  parameter int OCT_W   = oct_width(OCTAVES)
) (
  input  logic [3:0]       i_note,
  input  logic [OCT_W-1:0] i_oct,
  output logic [DIV_W-1:0] o_div
);

  logic [DIV_W-1:0] w_base;
  logic [OCT_W-1:0] w_shift;

  always_comb begin
    w_base  = DIV_W'(note_base(i_note));
    w_shift = OCT_W'(OCTAVES - 1) - i_oct;
    // Reload is one less than the half period because the phase counter
    // spends one cycle at zero before reloading.
    o_div   = (w_base << w_shift) - DIV_W'(1);
  end

endmodule

// File: rtl/tone_burst_gen.sv
// Tone-burst generator: plays `bursts` full square-wave periods on sound, then pulses done.
// Latency: busy one cycle after an accepted start; first rising edge divider+1 cycles later.
// Backpressure: start is ignored (dropped) while busy, for mode 3, or for bursts == 0.
//
// Ports: clk, rst (synchronous, active high), bus (tone_burst_gen_if.slave:
//        start/mode/bursts in; busy/sound/done out, all registered).
// Build option: define TONE_BURST_SCALE_EN to compile the chromatic scale
// mode (mode 2); without it mode 2 is treated like the reserved mode.
module tone_burst_gen
  import tone_pkg::*;
#(
  parameter int DIV_W      = 15,
  parameter int FIXED_DIV  = 28408,
  parameter int BURST_W    = 4,
  parameter int SWEEP_W    = 23,
  parameter int STEP_SHIFT = 22,
  parameter int OCTAVES    = 6
) (
  input logic             clk,
  input logic             rst,
  tone_burst_gen_if.slave bus
);

  localparam int TW = BURST_W + 1;
  localparam logic [DIV_W-1:0] FIXED_RELOAD = DIV_W'(FIXED_DIV);
  // Sweep divider with a cleared sweep counter: MSB low, so the ramp is
  // the inverse of zero, i.e. {01, 1111111, 0...}.
  localparam logic [DIV_W-1:0] SWEEP_DIV0 = DIV_W'(255) << (DIV_W - 9);

  if (DIV_W < 9) begin : g_bad_div_w
    $error("tone_burst_gen: DIV_W must be at least 9");
  end
  if (SWEEP_W < 8) begin : g_bad_sweep_w
    $error("tone_burst_gen: SWEEP_W must be at least 8");
  end
  if (OCTAVES < 1 || STEP_SHIFT < 1) begin : g_bad_scale_cfg
    $error("tone_burst_gen: OCTAVES and STEP_SHIFT must be at least 1");
  end

  tone_state_e        r_state, w_state_nxt;
  tone_mode_e         r_mode, w_mode_in;
  logic [BURST_W-1:0] r_bursts;
  logic [TW-1:0]      r_toggles, w_tog_inc;
  logic [DIV_W-1:0]   r_phase;
  logic [DIV_W-1:0]   w_div_run, w_div_start, w_div_sweep;
  logic [SWEEP_W-1:0] r_sweep;
  logic [6:0]         w_ramp;
  logic               r_busy, r_done, r_sound;
  logic               w_busy_nxt, w_done_nxt, w_sound_nxt;
  logic               w_legal, w_accept, w_reload, w_last;

`ifdef TONE_BURST_SCALE_EN
  localparam int OCT_W = oct_width(OCTAVES);
  localparam logic [OCT_W-1:0] OCT_MAX = OCT_W'(OCTAVES - 1);
  localparam logic [DIV_W-1:0] SCALE_DIV0 =
    DIV_W'((int'(NOTE_LUT[0]) << (OCTAVES - 1)) - 1);

  if ((512 << (OCTAVES - 1)) >= (1 << DIV_W)) begin : g_bad_octaves
    $error("tone_burst_gen: lowest scale note does not fit in DIV_W bits");
  end

  logic [STEP_SHIFT-1:0] r_step;
  logic [3:0]            r_note;
  logic [OCT_W-1:0]      r_oct;
  logic [DIV_W-1:0]      w_div_scale;

  tone_note_lut #(
    .DIV_W   (DIV_W),
    .OCTAVES (OCTAVES),
    .OCT_W   (OCT_W)
  ) u_note_lut (
    .i_note (r_note),
    .i_oct  (r_oct),
    .o_div  (w_div_scale)
  );
`endif

  // Request qualification.
  always_comb begin
    w_mode_in = tone_mode_e'(bus.mode);
    w_legal   = (w_mode_in == TONE_FIXED) || (w_mode_in == TONE_SWEEP);
`ifdef TONE_BURST_SCALE_EN
    if (w_mode_in == TONE_SCALE) w_legal = 1'b1;
`endif
    w_accept  = (r_state == ST_IDLE) && bus.start && w_legal && (bus.bursts != '0);
  end

  // Divider selection. w_div_run follows the live sweep/scale counters and
  // is only sampled at a reload; w_div_start is the same divider with all
  // counters cleared, used for the very first half period.
  always_comb begin
    w_ramp      = r_sweep[SWEEP_W-1] ? r_sweep[SWEEP_W-2 -: 7] : ~r_sweep[SWEEP_W-2 -: 7];
    w_div_sweep = DIV_W'({2'b01, w_ramp}) << (DIV_W - 9);

    w_div_run = FIXED_RELOAD;
    case (r_mode)
      TONE_SWEEP: w_div_run = w_div_sweep;
`ifdef TONE_BURST_SCALE_EN
      TONE_SCALE: w_div_run = w_div_scale;
`endif
      default: ;
    endcase

    w_div_start = FIXED_RELOAD;
    case (w_mode_in)
      TONE_SWEEP: w_div_start = SWEEP_DIV0;
`ifdef TONE_BURST_SCALE_EN
      TONE_SCALE: w_div_start = SCALE_DIV0;
`endif
      default: ;
    endcase
  end

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_sound_nxt = r_sound;
    w_reload    = (r_state == ST_RUN) && (r_phase == '0);
    w_tog_inc   = r_toggles + TW'(1);
    // 2*bursts toggles is always an even count, so the last one is a fall.
    w_last      = w_reload && (w_tog_inc == {r_bursts, 1'b0});

    case (r_state)
      ST_IDLE: begin
        w_busy_nxt  = 1'b0;
        w_sound_nxt = 1'b0;
        if (w_accept) begin
          w_state_nxt = ST_RUN;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_reload) begin
          w_sound_nxt = ~r_sound;
          if (w_last) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_sound_nxt = 1'b0;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_sound_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_sound_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sound <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_sound <= w_sound_nxt;
    end
  end

  // Phase, toggle and sweep counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode    <= TONE_FIXED;
      r_bursts  <= '0;
      r_toggles <= '0;
      r_phase   <= '0;
      r_sweep   <= '0;
    end else if (w_accept) begin
      r_mode    <= w_mode_in;
      r_bursts  <= bus.bursts;
      r_toggles <= '0;
      r_phase   <= w_div_start;
      r_sweep   <= '0;
    end else if (r_state == ST_RUN) begin
      r_sweep <= r_sweep + SWEEP_W'(1);
      if (w_reload) begin
        r_phase   <= w_div_run;
        r_toggles <= w_tog_inc;
      end else begin
        r_phase <= r_phase - DIV_W'(1);
      end
    end
  end

`ifdef TONE_BURST_SCALE_EN
  // Note advances when the step counter wraps; octave advances when the
  // note wraps past the last table entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= '0;
      r_note <= '0;
      r_oct  <= '0;
    end else if (w_accept) begin
      r_step <= '0;
      r_note <= '0;
      r_oct  <= '0;
    end else if (r_state == ST_RUN) begin
      r_step <= r_step + STEP_SHIFT'(1);
      if (r_step == '1) begin
        if (r_note == 4'(NOTE_CNT - 1)) begin
          r_note <= '0;
          r_oct  <= (r_oct == OCT_MAX) ? '0 : r_oct + OCT_W'(1);
        end else begin
          r_note <= r_note + 4'd1;
        end
      end
    end
  end
`endif

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.sound = r_sound;

endmodule
